para_regs_mc: RTL and testbench
===============================

PARA_REGS_MC -- requirements
Module: para_regs_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, number of channels (1..8).
REQ-002 SHALL have parameter CFG_BYTES, default 4, bytes per channel config register (1..4).
REQ-003 SHALL have parameter STA_BYTES, default 2, bytes per channel status input (1..4).
REQ-004 SHALL have parameter CFG_RST, default 32'h0000_0000, reset value of every channel config register (low CFG_BYTES*8 bits used).
REQ-005 SHALL have port clk_sys  input  1  system clock; all state on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port dev_id  input  6  device select value matched against address bits [21:16].
REQ-008 SHALL have port fx_wr  input  1  write strobe, one byte per cycle.
REQ-009 SHALL have port fx_waddr  input  22  write address: [21:16] device, [15:8] channel, [7:0] register.
REQ-010 SHALL have port fx_data  input  8  write data.
REQ-011 SHALL have port fx_rd  input  1  read strobe.
REQ-012 SHALL have port fx_raddr  input  22  read address, same fields as fx_waddr.
REQ-013 SHALL have port fx_q  output  8  registered read data.
REQ-014 SHALL have port cfg_out  output  NCH*CFG_BYTES*8  committed config registers, channel c at bits [c*CFG_BYTES*8 +: CFG_BYTES*8].
REQ-015 SHALL have port sta_in  input  NCH*STA_BYTES*8  live status per channel, same packing.
REQ-016 SHALL have port evt_in  input  NCH  per-channel single-cycle event pulses.
REQ-017 SHALL have port evt_flag  output  NCH  sticky per-channel event flags.
REQ-018 SHALL have port irq  output  1  OR of evt_flag.

Function
REQ-019 SHALL accept a write only when fx_wr=1 and fx_waddr[21:16]==dev_id; a read only when fx_rd=1 and fx_raddr[21:16]==dev_id.
REQ-020 SHALL map per channel c (c<NCH, address[15:8]=c): 0x00..CFG_BYTES-1 config bytes LSB first; 0x10..0x10+STA_BYTES-1 status bytes; 0x20 flag byte {7'b0,evt_flag[c]}; 0x21 8-bit event counter.
REQ-021 SHALL map global channel 0xFF: reg 0x00 reads {2'b00,dev_id}; reg 0x01 reads NCH; reg 0x02 reads irq status {(8-NCH)'b0,evt_flag}.
REQ-022 SHALL write config bytes 0..CFG_BYTES-2 into a per-channel shadow only; a write to byte CFG_BYTES-1 SHALL load the full shadow (with the new MSB) into cfg_out in that same clock edge (atomic commit, visible the cycle after the write).
REQ-023 SHALL, when CFG_BYTES=1, commit every byte write directly.
REQ-024 SHALL capture all STA_BYTES bytes of sta_in[c] into a snapshot on a read of status byte 0x10; reads of 0x11.. SHALL return snapshot bytes, not live input.
REQ-025 SHALL set evt_flag[c] on evt_in[c]=1; write to 0x20 with fx_data[0]=1 SHALL clear it (W1C); simultaneous set and clear SHALL leave it set.
REQ-026 SHALL increment counter[c] on evt_in[c], saturating at 8'hFF; any write to 0x21 SHALL clear it; simultaneous clear and event SHALL yield 8'h01.
REQ-027 SHALL register fx_q one cycle after the read strobe (latency 1); fx_q SHALL be 8'h00 when no valid read, unmapped register, channel >=NCH, or device mismatch.
REQ-028 SHALL return the pre-write value when read and write target the same register in the same cycle.
REQ-029 SHALL ignore writes to read-only, unmapped, or out-of-range addresses with no state change.
REQ-030 SHALL drive irq combinationally from evt_flag.

Reset
REQ-031 SHALL on rst=1, asynchronously: cfg_out and shadows = CFG_RST per channel, snapshots = 0, evt_flag = 0, counters = 0, fx_q = 8'h00, irq = 0.
REQ-032 SHALL discard any partially written shadow on reset; the next commit after reset SHALL use CFG_RST for unwritten bytes.

Verification
REQ-033 SHALL verify atomic commit: dev_id=5, write ch2 bytes 0x00..0x02=11,22,33 -> cfg_out ch2 unchanged; write 0x03=44 -> next cycle cfg_out ch2 = 32'h44332211.
REQ-034 SHALL verify snapshot: sta_in ch1=16'h1234, read 0x0110 -> fx_q=8'h34; change sta_in to 16'hABCD, read 0x0111 -> fx_q=8'h12.
REQ-035 SHALL verify event: evt_in[3] pulse x300 -> counter 0x21 reads 8'hFF, evt_flag[3]=1, irq=1; write 0x0320 data 8'h01 together with evt_in[3] pulse -> flag stays 1; next W1C alone -> flag 0, irq 0.
REQ-036 SHALL verify select: write with fx_waddr[21:16]=6 while dev_id=5 -> no change; read channel 0x04 with NCH=4 -> fx_q=8'h00.
REQ-037 SHALL verify reset mid-operation: write ch0 byte0=8'hAA, assert rst, release, write byte3=8'h55 -> cfg_out ch0 = {8'h55, CFG_RST[23:0]}.
REQ-038 SHALL verify global: read 0xFF00 -> {2'b00,dev_id}; read 0xFF01 -> 8'h04 with NCH=4.

Source files
------------

// File: rtl/para_regs_mc.sv
// Multi-channel byte-addressed register block: per-channel config with atomic
// multi-byte commit, status snapshots, sticky event flags and saturating event counters.
module para_regs_mc #(
    parameter int          NCH       = 4,
    parameter int          CFG_BYTES = 4,
    parameter int          STA_BYTES = 2,
    parameter logic [31:0] CFG_RST   = 32'h0000_0000
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic [5:0]                   dev_id,
    input  logic                         fx_wr,
    input  logic [21:0]                  fx_waddr,
    input  logic [7:0]                   fx_data,
    input  logic                         fx_rd,
    input  logic [21:0]                  fx_raddr,
    output logic [7:0]                   fx_q,
    output logic [NCH*CFG_BYTES*8-1:0]   cfg_out,
    input  logic [NCH*STA_BYTES*8-1:0]   sta_in,
    input  logic [NCH-1:0]               evt_in,
    output logic [NCH-1:0]               evt_flag,
    output logic                         irq
);

    localparam int CW = CFG_BYTES * 8;
    localparam int SW = STA_BYTES * 8;

    logic [CW-1:0]  cfg_q  [NCH];
    logic [CW-1:0]  cfg_d  [NCH];
    logic [CW-1:0]  shd_q  [NCH];
    logic [CW-1:0]  shd_d  [NCH];
    logic [SW-1:0]  snap_q [NCH];
    logic [SW-1:0]  snap_d [NCH];
    logic [7:0]     cnt_q  [NCH];
    logic [7:0]     cnt_d  [NCH];
    logic [NCH-1:0] flag_q;
    logic [NCH-1:0] flag_d;
    logic [7:0]     fx_d;

    logic       wr_hit_s;
    logic       rd_hit_s;
    logic [7:0] wch_s;
    logic [7:0] wreg_s;
    logic [7:0] rch_s;
    logic [7:0] rreg_s;
    logic [7:0] rdata_s;
    logic [7:0] flag_byte_s;

    assign wr_hit_s    = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_hit_s    = fx_rd && (fx_raddr[21:16] == dev_id);
    assign wch_s       = fx_waddr[15:8];
    assign wreg_s      = fx_waddr[7:0];
    assign rch_s       = fx_raddr[15:8];
    assign rreg_s      = fx_raddr[7:0];
    assign flag_byte_s = 8'(flag_q);
    assign evt_flag    = flag_q;
    assign irq         = |flag_q;

    // Pack committed config registers onto the output bus.
    always_comb begin
        cfg_out = '0;
        for (int c = 0; c < NCH; c++) begin
            cfg_out[c*CW +: CW] = cfg_q[c];
        end
    end

    // Next-state for per-channel state; the last config byte commits the shadow.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            cfg_d[c]  = cfg_q[c];
            shd_d[c]  = shd_q[c];
            snap_d[c] = snap_q[c];
            cnt_d[c]  = cnt_q[c];
            flag_d[c] = flag_q[c];

            if (wr_hit_s && (wch_s == 8'(c))) begin
                for (int b = 0; b < CFG_BYTES; b++) begin
                    if (wreg_s == 8'(b)) begin
                        shd_d[c][b*8 +: 8] = fx_data;
                        if (b == CFG_BYTES - 1) begin
                            cfg_d[c] = shd_d[c];
                        end else begin
                            cfg_d[c] = cfg_q[c];
                        end
                    end else begin
                        shd_d[c][b*8 +: 8] = shd_d[c][b*8 +: 8];
                    end
                end
            end else begin
                shd_d[c] = shd_q[c];
            end

            if (rd_hit_s && (rch_s == 8'(c)) && (rreg_s == 8'h10)) begin
                snap_d[c] = sta_in[c*SW +: SW];
            end else begin
                snap_d[c] = snap_q[c];
            end

            // A set in the same cycle as a W1C wins.
            if (evt_in[c]) begin
                flag_d[c] = 1'b1;
            end else if (wr_hit_s && (wch_s == 8'(c)) && (wreg_s == 8'h20) && fx_data[0]) begin
                flag_d[c] = 1'b0;
            end else begin
                flag_d[c] = flag_q[c];
            end

            if (wr_hit_s && (wch_s == 8'(c)) && (wreg_s == 8'h21)) begin
                cnt_d[c] = evt_in[c] ? 8'h01 : 8'h00;
            end else if (evt_in[c] && (cnt_q[c] != 8'hFF)) begin
                cnt_d[c] = cnt_q[c] + 8'h01;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    // Read mux over pre-write state; status byte 0 returns the value being captured.
    always_comb begin
        rdata_s = 8'h00;
        if (rch_s == 8'hFF) begin
            case (rreg_s)
                8'h00:   rdata_s = {2'b00, dev_id};
                8'h01:   rdata_s = 8'(NCH);
                8'h02:   rdata_s = flag_byte_s;
                default: rdata_s = 8'h00;
            endcase
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (rch_s == 8'(c)) begin
                    for (int b = 0; b < CFG_BYTES; b++) begin
                        rdata_s = (rreg_s == 8'(b)) ? cfg_q[c][b*8 +: 8] : rdata_s;
                    end
                    for (int b = 0; b < STA_BYTES; b++) begin
                        if (rreg_s == 8'(16 + b)) begin
                            rdata_s = (b == 0) ? sta_in[c*SW +: 8] : snap_q[c][b*8 +: 8];
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                    if (rreg_s == 8'h20) begin
                        rdata_s = {7'b000_0000, flag_q[c]};
                    end else if (rreg_s == 8'h21) begin
                        rdata_s = cnt_q[c];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end
        fx_d = rd_hit_s ? rdata_s : 8'h00;
    end

    // State registers.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                cfg_q[c]  <= CFG_RST[CW-1:0];
                shd_q[c]  <= CFG_RST[CW-1:0];
                snap_q[c] <= '0;
                cnt_q[c]  <= 8'h00;
            end
            flag_q <= '0;
            fx_q   <= 8'h00;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cfg_q[c]  <= cfg_d[c];
                shd_q[c]  <= shd_d[c];
                snap_q[c] <= snap_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            flag_q <= flag_d;
            fx_q   <= fx_d;
        end
    end

endmodule

// File: tb/tb_para_regs_mc.sv
// Directed bench for para_regs_mc: a vector table for decode/commit/select plus
// hand sequences for snapshot, event counters, W1C races and mid-operation reset.
module tb_para_regs_mc;

    localparam logic [31:0] CRST = 32'hA5A5_5A5A;

    logic         clk_sys = 1'b0;
    logic         rst;
    logic [5:0]   dev_id;
    logic         fx_wr;
    logic [21:0]  fx_waddr;
    logic [7:0]   fx_data;
    logic         fx_rd;
    logic [21:0]  fx_raddr;
    logic [7:0]   fx_q;
    logic [127:0] cfg_out;
    logic [63:0]  sta_in;
    logic [3:0]   evt_in;
    logic [3:0]   evt_flag;
    logic         irq;

    int errors = 0;
    int checks = 0;

    para_regs_mc #(.NCH(4), .CFG_BYTES(4), .STA_BYTES(2), .CFG_RST(CRST)) dut (
        .clk_sys(clk_sys), .rst(rst), .dev_id(dev_id), .fx_wr(fx_wr), .fx_waddr(fx_waddr),
        .fx_data(fx_data), .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q), .cfg_out(cfg_out),
        .sta_in(sta_in), .evt_in(evt_in), .evt_flag(evt_flag), .irq(irq)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        wr;
        logic [21:0] waddr;
        logic [7:0]  wdata;
        logic        rd;
        logic [21:0] raddr;
        logic [7:0]  exp_q;
        logic [31:0] exp_cfg2;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [21:0] ad(input logic [5:0] d, input logic [7:0] ch, input logic [7:0] r);
        return {d, ch, r};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change right after a falling edge; outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic wr(input logic [7:0] ch, input logic [7:0] r, input logic [7:0] d);
        fx_wr = 1'b1; fx_waddr = ad(6'd5, ch, r); fx_data = d;
        step();
        fx_wr = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] ch, input logic [7:0] r, input logic [7:0] exp);
        fx_rd = 1'b1; fx_raddr = ad(6'd5, ch, r);
        step();
        fx_rd = 1'b0;
        check(name, {120'd0, fx_q}, {120'd0, exp});
    endtask

    initial begin
        rst = 1'b1; dev_id = 6'd5; fx_wr = 1'b0; fx_waddr = '0; fx_data = 8'h00;
        fx_rd = 1'b0; fx_raddr = '0; sta_in = '0; evt_in = '0;

        vecs[0]  = '{1'b0, ad(5, 8'h00, 8'h00), 8'h00, 1'b1, ad(5, 8'hFF, 8'h00), 8'h05, CRST};
        vecs[1]  = '{1'b0, ad(5, 8'h00, 8'h00), 8'h00, 1'b1, ad(5, 8'hFF, 8'h01), 8'h04, CRST};
        vecs[2]  = '{1'b1, ad(5, 8'h02, 8'h00), 8'h11, 1'b1, ad(5, 8'h02, 8'h00), 8'h5A, CRST};
        vecs[3]  = '{1'b1, ad(5, 8'h02, 8'h01), 8'h22, 1'b0, ad(5, 8'h02, 8'h01), 8'h00, CRST};
        vecs[4]  = '{1'b1, ad(5, 8'h02, 8'h02), 8'h33, 1'b1, ad(5, 8'h02, 8'h02), 8'hA5, CRST};
        vecs[5]  = '{1'b1, ad(5, 8'h02, 8'h03), 8'h44, 1'b1, ad(5, 8'h02, 8'h03), 8'hA5, 32'h4433_2211};
        vecs[6]  = '{1'b0, ad(5, 8'h02, 8'h03), 8'h00, 1'b1, ad(5, 8'h02, 8'h03), 8'h44, 32'h4433_2211};
        vecs[7]  = '{1'b1, ad(6, 8'h02, 8'h03), 8'h77, 1'b1, ad(6, 8'h02, 8'h00), 8'h00, 32'h4433_2211};
        vecs[8]  = '{1'b1, ad(5, 8'h04, 8'h03), 8'h66, 1'b1, ad(5, 8'h04, 8'h00), 8'h00, 32'h4433_2211};
        vecs[9]  = '{1'b1, ad(5, 8'h02, 8'h05), 8'h99, 1'b1, ad(5, 8'h02, 8'h05), 8'h00, 32'h4433_2211};
        vecs[10] = '{1'b1, ad(5, 8'h02, 8'h10), 8'hFF, 1'b1, ad(5, 8'hFF, 8'h02), 8'h00, 32'h4433_2211};
        vecs[11] = '{1'b0, ad(5, 8'h00, 8'h00), 8'h00, 1'b1, ad(5, 8'h00, 8'h00), 8'h5A, 32'h4433_2211};
        vecs[12] = '{1'b1, ad(5, 8'hFF, 8'h00), 8'h01, 1'b1, ad(5, 8'h02, 8'h01), 8'h22, 32'h4433_2211};
        vecs[13] = '{1'b0, ad(5, 8'h02, 8'h03), 8'h00, 1'b0, ad(5, 8'h02, 8'h00), 8'h00, 32'h4433_2211};

        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        check("rst_cfg", cfg_out, {4{CRST}});
        check("rst_fxq", {120'd0, fx_q}, 128'd0);
        check("rst_flag", {124'd0, evt_flag}, 128'd0);
        check("rst_irq", {127'd0, irq}, 128'd0);

        for (int i = 0; i < 14; i++) begin
            fx_wr = vecs[i].wr; fx_waddr = vecs[i].waddr; fx_data = vecs[i].wdata;
            fx_rd = vecs[i].rd; fx_raddr = vecs[i].raddr;
            step();
            check($sformatf("vec%0d_q", i), {120'd0, fx_q}, {120'd0, vecs[i].exp_q});
            check($sformatf("vec%0d_cfg2", i), {96'd0, cfg_out[64 +: 32]}, {96'd0, vecs[i].exp_cfg2});
        end
        fx_wr = 1'b0; fx_rd = 1'b0;
        check("other_ch_cfg", {cfg_out[127:96], cfg_out[63:0]}, {CRST, CRST, CRST});

        // Status snapshot: byte 0 captures, later bytes come from the snapshot.
        sta_in[16 +: 16] = 16'h1234;
        rd("snap_b0", 8'h01, 8'h10, 8'h34);
        sta_in[16 +: 16] = 16'hABCD;
        rd("snap_b1", 8'h01, 8'h11, 8'h12);
        rd("snap_b0_new", 8'h01, 8'h10, 8'hCD);
        rd("snap_b1_new", 8'h01, 8'h11, 8'hAB);

        // Event counter saturation and sticky flag.
        for (int i = 0; i < 3; i++) begin
            evt_in[3] = 1'b1; step(); evt_in[3] = 1'b0; step();
        end
        rd("cnt_3", 8'h03, 8'h21, 8'h03);
        for (int i = 0; i < 297; i++) begin
            evt_in[3] = 1'b1; step(); evt_in[3] = 1'b0; step();
        end
        rd("cnt_sat", 8'h03, 8'h21, 8'hFF);
        check("flag_set", {124'd0, evt_flag}, 128'h8);
        check("irq_set", {127'd0, irq}, 128'd1);
        rd("irq_byte", 8'hFF, 8'h02, 8'h08);
        rd("flag_byte", 8'h03, 8'h20, 8'h01);

        evt_in[3] = 1'b1;
        wr(8'h03, 8'h20, 8'h01);
        evt_in[3] = 1'b0;
        check("w1c_race_flag", {124'd0, evt_flag}, 128'h8);
        rd("cnt_still_sat", 8'h03, 8'h21, 8'hFF);
        wr(8'h03, 8'h20, 8'h01);
        check("w1c_flag", {124'd0, evt_flag}, 128'd0);
        check("w1c_irq", {127'd0, irq}, 128'd0);

        evt_in[3] = 1'b1;
        wr(8'h03, 8'h21, 8'h00);
        evt_in[3] = 1'b0;
        rd("cnt_clr_race", 8'h03, 8'h21, 8'h01);
        wr(8'h03, 8'h20, 8'hFE);
        check("w1c_bit0_zero", {124'd0, evt_flag}, 128'h8);
        wr(8'h03, 8'h20, 8'h01);
        wr(8'h03, 8'h21, 8'h5A);
        rd("cnt_clr", 8'h03, 8'h21, 8'h00);
        check("flag_final", {124'd0, evt_flag}, 128'd0);

        // Reset in the middle of a partial config write.
        wr(8'h00, 8'h00, 8'hAA);
        fx_rd = 1'b1; fx_raddr = ad(6'd5, 8'hFF, 8'h00);
        @(posedge clk_sys);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cfg", cfg_out, {4{CRST}});
        check("async_rst_fxq", {120'd0, fx_q}, 128'd0);
        fx_rd = 1'b0;
        @(negedge clk_sys);
        rst = 1'b0;
        wr(8'h00, 8'h03, 8'h55);
        check("rst_partial_commit", {96'd0, cfg_out[31:0]}, {96'd0, 8'h55, CRST[23:0]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
